// File: rtl/offchip_link_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : offchip_link_arbiter
// Brief    : Round-robin, burst-bounded arbiter sharing one byte link between
//            two producers, gated by a downstream nibble-slot credit counter.
// Revision : 1.0 - initial release
// ============================================================================
module offchip_link_arbiter #(
    parameter int CREDIT_MAX     = 8,
    parameter int SLOTS_PER_BYTE = 2,
    parameter int CREDIT_RET     = 4,
    parameter int BURST_MAX      = 4,
    parameter int CW             = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    input  logic [7:0]    req0_data,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [7:0]    req1_data,
    output logic          req1_ready,
    output logic [7:0]    link_data,
    output logic          link_valid,
    input  logic          link_ready,
    input  logic          credit_ret,
    output logic [CW-1:0] credit_cnt,
    output logic          grant_id,
    output logic          credit_stall,
    output logic          err_credit
);

    localparam int              c_bw        = $clog2(BURST_MAX + 1);
    localparam logic [c_bw-1:0] c_burst_max = c_bw'(BURST_MAX);
    localparam logic [CW:0]     c_slots     = (CW + 1)'(SLOTS_PER_BYTE);
    localparam logic [CW:0]     c_slots2    = (CW + 1)'(2 * SLOTS_PER_BYTE);
    localparam logic [CW:0]     c_ret       = (CW + 1)'(CREDIT_RET);
    localparam logic [CW:0]     c_max       = (CW + 1)'(CREDIT_MAX);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      link_data_q, link_data_d;
    logic            grant_id_q, grant_id_d;
    logic [CW-1:0]   credit_q, credit_d;
    logic            err_q, err_d;
    logic [c_bw-1:0] burst_q, burst_d;
    logic            rr_q, rr_d;

    logic            w_hs;
    logic            w_take;
    logic            w_sel;
    logic [CW:0]     w_credit_sum;

    always_comb begin
        state_d     = state_q;
        link_data_d = link_data_q;
        grant_id_d  = grant_id_q;
        credit_d    = credit_q;
        err_d       = err_q;
        burst_d     = burst_q;
        rr_d        = rr_q;
        w_take      = 1'b0;
        w_sel       = 1'b0;
        w_hs        = (state_q == SEND) & link_ready;

        // Send and return apply together; any overshoot saturates and is flagged.
        w_credit_sum = {1'b0, credit_q} - (w_hs ? c_slots : '0) + (credit_ret ? c_ret : '0);
        if (w_credit_sum > c_max) begin
            credit_d = c_max[CW-1:0];
            err_d    = 1'b1;
        end else begin
            credit_d = w_credit_sum[CW-1:0];
        end

        case (state_q)
            IDLE: begin
                w_sel = (req0_valid & req1_valid) ? rr_q : req1_valid;
                if ((req0_valid | req1_valid) && ({1'b0, credit_q} >= c_slots)) begin
                    w_take  = 1'b1;
                    burst_d = c_bw'(1);
                    state_d = SEND;
                end
            end
            SEND: begin
                w_sel = grant_id_q;
                if (link_ready) begin
                    // The byte still on the link has not been debited yet, so
                    // the next one needs two bytes' worth of credit.
                    if ((grant_id_q ? req1_valid : req0_valid) &&
                        (burst_q < c_burst_max) &&
                        ({1'b0, credit_q} >= c_slots2)) begin
                        w_take  = 1'b1;
                        burst_d = burst_q + c_bw'(1);
                    end else begin
                        rr_d    = ~grant_id_q;
                        burst_d = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (w_take) begin
            link_data_d = w_sel ? req1_data : req0_data;
            grant_id_d  = w_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            link_data_q <= '0;
            grant_id_q  <= 1'b0;
            credit_q    <= c_max[CW-1:0];
            err_q       <= 1'b0;
            burst_q     <= '0;
            rr_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            link_data_q <= link_data_d;
            grant_id_q  <= grant_id_d;
            credit_q    <= credit_d;
            err_q       <= err_d;
            burst_q     <= burst_d;
            rr_q        <= rr_d;
        end
    end

    // A byte offered during reset would be lost, so never acknowledge it.
    assign req0_ready   = w_take & ~w_sel & ~rst;
    assign req1_ready   = w_take &  w_sel & ~rst;
    assign link_valid   = (state_q == SEND);
    assign link_data    = link_data_q;
    assign grant_id     = grant_id_q;
    assign credit_cnt   = credit_q;
    assign err_credit   = err_q;
    assign credit_stall = (req0_valid | req1_valid) & ({1'b0, credit_q} < c_slots);

endmodule
`default_nettype wire

// File: tb/tb_offchip_link_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_offchip_link_arbiter
// Brief    : Directed scenarios plus randomized traffic against a
//            transaction-level model of the link arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_offchip_link_arbiter;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
    logic       link_ready = 1'b0, credit_ret = 1'b0;
    logic       req0_ready, req1_ready, link_valid, grant_id, credit_stall, err_credit;
    logic [7:0] link_data;
    logic [4:0] credit_cnt;

    offchip_link_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .req0_valid   (req0_valid),
        .req0_data    (req0_data),
        .req0_ready   (req0_ready),
        .req1_valid   (req1_valid),
        .req1_data    (req1_data),
        .req1_ready   (req1_ready),
        .link_data    (link_data),
        .link_valid   (link_valid),
        .link_ready   (link_ready),
        .credit_ret   (credit_ret),
        .credit_cnt   (credit_cnt),
        .grant_id     (grant_id),
        .credit_stall (credit_stall),
        .err_credit   (err_credit)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Transaction-level model: credits as an integer, the byte on the wire,
    // who owns it, how many bytes the current owner has had in a row, and
    // which channel is favoured on the next contention.
    bit       m_known = 1'b0;
    int       m_credit;
    bit       m_err, m_busy, m_owner, m_pref;
    bit [7:0] m_data;
    int       m_run;
    bit       e_r0, e_r1, e_stall;
    bit       s_r0, s_r1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_eval();
        int  room;
        bit  win;
        room = m_busy ? m_credit - 2 : m_credit;
        e_r0 = 1'b0;
        e_r1 = 1'b0;
        if (!rst) begin
            if (!m_busy) begin
                win = (req0_valid && req1_valid) ? m_pref : req1_valid;
                if ((req0_valid || req1_valid) && room >= 2) begin
                    e_r0 = !win;
                    e_r1 = win;
                end
            end else if (link_ready && m_run < 4 && room >= 2 &&
                         (m_owner ? req1_valid : req0_valid)) begin
                e_r0 = !m_owner;
                e_r1 = m_owner;
            end
        end
        e_stall = (req0_valid || req1_valid) && m_credit < 2;
    endfunction

    function automatic void model_commit();
        int nxt;
        if (rst) begin
            m_known = 1'b1; m_credit = 8; m_err = 1'b0; m_busy = 1'b0;
            m_owner = 1'b0; m_pref = 1'b0; m_data = 8'h00; m_run = 0;
            return;
        end
        nxt = m_credit - ((m_busy && link_ready) ? 2 : 0) + (credit_ret ? 4 : 0);
        if (nxt > 8) begin
            nxt   = 8;
            m_err = 1'b1;
        end
        m_credit = nxt;
        if (e_r0 || e_r1) begin
            m_run   = m_busy ? m_run + 1 : 1;
            m_busy  = 1'b1;
            m_owner = e_r1;
            m_data  = e_r1 ? req1_data : req0_data;
        end else if (m_busy && link_ready) begin
            m_busy = 1'b0;
            m_pref = !m_owner;
            m_run  = 0;
        end
    endfunction

    // One clock: drive, compare mid-cycle against the model, then advance.
    task automatic step(input bit r, input bit v0, input logic [7:0] d0,
                        input bit v1, input logic [7:0] d1, input bit lr, input bit cr);
        rst = r; req0_valid = v0; req0_data = d0; req1_valid = v1; req1_data = d1;
        link_ready = lr; credit_ret = cr;
        #3;
        model_eval();
        s_r0 = req0_ready;
        s_r1 = req1_ready;
        if (m_known) begin
            chk("req0_ready", req0_ready, e_r0);
            chk("req1_ready", req1_ready, e_r1);
            chk("link_valid", link_valid, m_busy);
            chk("credit_cnt", credit_cnt, m_credit);
            chk("credit_stall", credit_stall, e_stall);
            chk("err_credit", err_credit, m_err);
            if (m_busy) begin
                chk("link_data", link_data, m_data);
                chk("grant_id", grant_id, m_owner);
            end
        end
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic do_reset();
        step(1, 0, 8'h00, 0, 8'h00, 0, 0);
    endtask

    initial begin
        // Reset state and a single byte from ch0.
        do_reset();
        chk("rst_link_valid", link_valid, 1'b0);
        chk("rst_link_data", link_data, 8'h00);
        chk("rst_credit", credit_cnt, 5'd8);
        chk("rst_err", err_credit, 1'b0);
        step(0, 1, 8'h05, 0, 8'h00, 1, 0);
        chk("t1_ready_pulse", s_r0, 1'b1);
        chk("t1_link_data", link_data, 8'h05);
        chk("t1_link_valid", link_valid, 1'b1);
        chk("t1_grant", grant_id, 1'b0);
        step(0, 0, 8'h00, 0, 8'h00, 1, 0);
        chk("t1_credit_after", credit_cnt, 5'd6);
        chk("t1_model_credit", m_credit, 6);

        // Credit exhaustion with no returns, then a single return.
        begin : t3
            logic [7:0] d;
            do_reset();
            d = 8'hA0;
            for (int c = 0; c < 8; c++) begin
                step(0, 1, d, 0, 8'h00, 1, 0);
                if (s_r0) d++;
            end
            chk("t3_next_byte", d, 8'hA4);
            chk("t3_credit", credit_cnt, 5'd0);
            chk("t3_stall", credit_stall, 1'b1);
            chk("t3_link_valid", link_valid, 1'b0);
            step(0, 1, d, 0, 8'h00, 1, 1);
            chk("t3_credit_ret", credit_cnt, 5'd4);
            step(0, 1, d, 0, 8'h00, 1, 0);
            chk("t3_accept_a4", s_r0, 1'b1);
            chk("t3_link_a4", link_data, 8'hA4);
        end

        // Backpressure holds the byte and credits; then one handshake.
        do_reset();
        step(0, 1, 8'h33, 0, 8'h00, 0, 0);
        for (int c = 0; c < 3; c++) begin
            step(0, 1, 8'h34, 0, 8'h00, 0, 0);
            chk("t4_no_ready", s_r0, 1'b0);
            chk("t4_hold_data", link_data, 8'h33);
            chk("t4_hold_credit", credit_cnt, 5'd8);
        end
        step(0, 1, 8'h34, 0, 8'h00, 1, 0);
        chk("t4_continue", s_r0, 1'b1);
        chk("t4_next_data", link_data, 8'h34);
        chk("t4_credit", credit_cnt, 5'd6);

        // Return coincident with a handshake, then saturation.
        step(0, 0, 8'h00, 0, 8'h00, 1, 0);
        chk("t5_credit4", credit_cnt, 5'd4);
        step(0, 1, 8'h35, 0, 8'h00, 0, 0);
        step(0, 0, 8'h00, 0, 8'h00, 1, 1);
        chk("t5_net_plus2", credit_cnt, 5'd6);
        chk("t5_no_err", err_credit, 1'b0);
        step(0, 0, 8'h00, 0, 8'h00, 0, 1);
        chk("t5_saturate", credit_cnt, 5'd8);
        chk("t5_err", err_credit, 1'b1);
        step(0, 0, 8'h00, 0, 8'h00, 0, 0);
        chk("t5_err_sticky", err_credit, 1'b1);

        // Reset in the middle of a burst.
        step(0, 1, 8'h50, 0, 8'h00, 0, 0);
        chk("t6_busy", link_valid, 1'b1);
        step(1, 0, 8'h00, 0, 8'h00, 0, 0);
        chk("t6_link_valid", link_valid, 1'b0);
        chk("t6_credit", credit_cnt, 5'd8);
        chk("t6_grant", grant_id, 1'b0);
        chk("t6_err", err_credit, 1'b0);
        step(0, 1, 8'h60, 1, 8'h70, 0, 0);
        chk("t6_ch0_wins", s_r0, 1'b1);
        chk("t6_ch1_waits", s_r1, 1'b0);
        chk("t6_data", link_data, 8'h60);

        // Both channels saturating the link: bursts of four, alternating.
        begin : t2
            logic [7:0] d0, d1;
            int seq[$];
            int run, maxrun, last;
            do_reset();
            d0 = 8'h10; d1 = 8'h20;
            for (int c = 0; c < 30; c++) begin
                step(0, 1, d0, 1, d1, 1, c[0]);
                if (s_r0) begin seq.push_back(0); d0++; end
                if (s_r1) begin seq.push_back(1); d1++; end
            end
            for (int i = 0; i < 8; i++)
                chk("t2_order", (i < seq.size()) ? seq[i] : 9, (i / 4) % 2);
            run = 0; maxrun = 0; last = -1;
            foreach (seq[i]) begin
                run    = (seq[i] == last) ? run + 1 : 1;
                last   = seq[i];
                maxrun = (run > maxrun) ? run : maxrun;
            end
            chk("t2_max_burst", maxrun, 4);
        end

        // Randomized traffic, backpressure, returns and occasional resets.
        begin : rnd
            bit         v0, v1;
            logic [7:0] d0, d1;
            v0 = 1'b0; v1 = 1'b0; d0 = 8'h00; d1 = 8'h00;
            do_reset();
            for (int c = 0; c < 4000; c++) begin
                if (!v0 && $urandom_range(2) == 0) begin v0 = 1'b1; d0 = 8'($urandom); end
                if (!v1 && $urandom_range(2) == 0) begin v1 = 1'b1; d1 = 8'($urandom); end
                step($urandom_range(249) == 0, v0, d0, v1, d1,
                     $urandom_range(3) != 0, $urandom_range(4) == 0);
                if (e_r0) v0 = 1'b0;
                if (e_r1) v1 = 1'b0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/offchip_link_arbiter.md
Name: offchip_link_arbiter

Overview:
- Shares one off-chip byte link between two byte producers (ch0, ch1).
- Each granted byte occupies 2 nibble slots in the far-side 8-entry nibble memory.
- The block gates sending on a slot-credit counter that is replenished by read-side token pulses.
- Arbitration is round-robin with a bounded burst length; the link serializer sits downstream of link_data/link_valid.

Parameters:
- CREDIT_MAX, 8, nibble slots available downstream (credit counter reset value and ceiling).
- SLOTS_PER_BYTE, 2, slots consumed per byte sent.
- CREDIT_RET, 4, slots returned per credit_ret pulse.
- BURST_MAX, 4, max consecutive bytes granted to one channel before rotation.
- CW, 5, credit counter width.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- req0_valid  input  1  ch0 has a byte.
- req0_data  input  8  ch0 byte.
- req0_ready  output  1  ch0 byte accepted this cycle (combinational).
- req1_valid  input  1  ch1 has a byte.
- req1_data  input  8  ch1 byte.
- req1_ready  output  1  ch1 byte accepted this cycle (combinational).
- link_data  output  8  registered byte to serializer.
- link_valid  output  1  link_data valid.
- link_ready  input  1  serializer accepts link_data.
- credit_ret  input  1  one-cycle pulse returning CREDIT_RET slots.
- credit_cnt  output  CW  current slot credits.
- grant_id  output  1  channel owning link_data (valid while link_valid).
- credit_stall  output  1  request pending but credit_cnt < SLOTS_PER_BYTE.
- err_credit  output  1  sticky: a return would exceed CREDIT_MAX.

Behaviour:
- Reset values: link_valid=0, link_data=0, grant_id=0, credit_cnt=CREDIT_MAX, err_credit=0, burst_cnt=0, state=IDLE, rr_ptr=0 (ch0 preferred first).
- Reset mid-burst drops link_valid next cycle and discards the in-flight byte with no credit change.
- Credits:
  - credit_next = credit_cnt − (link_valid&link_ready ? SLOTS_PER_BYTE : 0) + (credit_ret ? CREDIT_RET : 0).
  - Simultaneous send and return apply both (net +2 with defaults).
  - If credit_next > CREDIT_MAX, saturate at CREDIT_MAX and set err_credit.
  - Never underflows, because a byte is captured only when it is covered by credit.
- can_send = credit_cnt ≥ SLOTS_PER_BYTE in IDLE. In SEND, can_send = (credit_cnt − SLOTS_PER_BYTE) ≥ SLOTS_PER_BYTE, ignoring a same-cycle credit_ret (a conservative rule).
- FSM state IDLE:
  - Winner = the requester whose valid is set. If both are valid, winner = rr_ptr.
  - If there is a winner and can_send: winner's reqN_ready=1, link_data<=reqN_data, grant_id<=winner, link_valid<=1, burst_cnt<=1, go SEND.
  - Otherwise stay in IDLE. credit_stall=1 when any req is valid and credit is insufficient.
- FSM state SEND:
  - link_valid held. link_data is stable until link_ready.
  - On link_ready, continue if: same channel valid, burst_cnt < BURST_MAX, and can_send.
    - Continue: that channel's ready=1, capture the next byte back-to-back (zero bubble), burst_cnt+1, stay in SEND.
    - Otherwise: link_valid<=0, rr_ptr<=~grant_id, burst_cnt<=0, go IDLE.
- Fairness: after a burst ends, the other channel wins the next contention. A lone requester regrants after one idle cycle.
- reqN_ready is never asserted for a non-granted channel and never asserted while link_valid&~link_ready.
- Requester contract: data must be stable while valid is high and ready is low.
- Latency: request accepted in IDLE → link_valid on the next cycle. Throughput is up to 1 byte/cycle within a burst, subject to credits.

Test Plan:
1. Reset, ch0 sends 0x05 with link_ready=1 → req0_ready pulse in cycle 0; link_data=0x05, link_valid=1, grant_id=0 in cycle 1; credit_cnt 8→6 after handshake.
2. Both channels continuously valid (ch0 0x10.., ch1 0x20..), link_ready=1, credit_ret every 2 cycles → 4 ch0 bytes, one IDLE cycle, 4 ch1 bytes, alternating. No channel exceeds 4 consecutive.
3. No credit_ret, ch0 streams 0xA0..0xA4 → exactly 4 bytes sent, credit_cnt=0, credit_stall=1, link_valid=0. One credit_ret pulse → credit_cnt=4, next byte 0xA4 accepted.
4. link_ready held low 3 cycles with link_data=0x33 → link_data stable, no reqN_ready, credit_cnt unchanged. link_ready=1 → handshake, credit −2.
5. credit_ret coincident with handshake at credit_cnt=4 → credit_cnt=6. credit_ret at credit_cnt=6 → saturates at 8, err_credit=1 and stays set.
6. rst asserted mid-burst (link_valid=1) → next cycle link_valid=0, credit_cnt=8, grant_id=0, err_credit=0. Both requesting afterward → ch0 wins.
